// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection and flush.
// Define ID_EX_STATS_EN to build the instruction/bubble counters; otherwise they read 0.
module id_ex_latch #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEMREAD_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [1:0]        ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic [3:0]        ctlex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic [DATA_W-1:0] signext_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              valid_out,
  output logic [1:0]        ctlwb_out,
  output logic [2:0]        ctlm_out,
  output logic [3:0]        ctlex_out,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic [DATA_W-1:0] signext_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              stall,
  output logic [31:0]       bubble_count,
  output logic [31:0]       instr_count
);

  logic load_bubble;
  logic rt_hit;

  // A load in EX whose destination feeds the decode instruction; $zero never hazards.
  assign rt_hit      = (rt_out != '0) && ((rt_out == rs_in) || (rt_out == rt_in));
  assign stall       = valid_out & ctlm_out[MEMREAD_BIT] & valid_in & rt_hit;
  assign load_bubble = flush | stall;

  // Control and valid are killed on a bubble; data fields hold to avoid needless toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      ctlwb_out   <= '0;
      ctlm_out    <= '0;
      ctlex_out   <= '0;
      npc_out     <= '0;
      A_out       <= '0;
      B_out       <= '0;
      signext_out <= '0;
      rt_out      <= '0;
      rd_out      <= '0;
    end else if (load_bubble) begin
      valid_out   <= 1'b0;
      ctlwb_out   <= '0;
      ctlm_out    <= '0;
      ctlex_out   <= '0;
    end else begin
      valid_out   <= valid_in;
      ctlwb_out   <= ctlwb_in;
      ctlm_out    <= ctlm_in;
      ctlex_out   <= ctlex_in;
      npc_out     <= npc_in;
      A_out       <= A_in;
      B_out       <= B_in;
      signext_out <= signext_in;
      rt_out      <= rt_in;
      rd_out      <= rd_in;
    end
  end

`ifdef ID_EX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count  <= '0;
      bubble_count <= '0;
    end else if (load_bubble) begin
      bubble_count <= bubble_count + 32'd1;
    end else if (valid_in) begin
      instr_count  <= instr_count + 32'd1;
    end
  end
`else
  assign instr_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// Scoreboard bench for id_ex_latch: stimulus pushes expected EX-slot contents, a monitor pops/compares.
module tb_id_ex_latch;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, valid_in = 1'b0;
  logic [1:0]  ctlwb_in = '0;
  logic [2:0]  ctlm_in = '0;
  logic [3:0]  ctlex_in = '0;
  logic [31:0] npc_in = '0, A_in = '0, B_in = '0, signext_in = '0;
  logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0;
  logic        valid_out, stall;
  logic [1:0]  ctlwb_out;
  logic [2:0]  ctlm_out;
  logic [3:0]  ctlex_out;
  logic [31:0] npc_out, A_out, B_out, signext_out, bubble_count, instr_count;
  logic [4:0]  rt_out, rd_out;

  id_ex_latch #(.DATA_W(32), .REG_AW(5), .MEMREAD_BIT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .A_in(A_in), .B_in(B_in), .signext_in(signext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .valid_out(valid_out), .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
    .npc_out(npc_out), .A_out(A_out), .B_out(B_out), .signext_out(signext_out),
    .rt_out(rt_out), .rd_out(rd_out), .stall(stall),
    .bubble_count(bubble_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, a, b, sx;
    logic [4:0]  rt, rd;
    logic [31:0] ic, bc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0, n_fail = 0;
  logic stats_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge that has an outstanding expectation is compared.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valid_out", {31'd0, valid_out}, {31'd0, e.v});
      chk("ctlwb_out", {30'd0, ctlwb_out}, {30'd0, e.wb});
      chk("ctlm_out", {29'd0, ctlm_out}, {29'd0, e.m});
      chk("ctlex_out", {28'd0, ctlex_out}, {28'd0, e.ex});
      chk("npc_out", npc_out, e.npc);
      chk("A_out", A_out, e.a);
      chk("B_out", B_out, e.b);
      chk("signext_out", signext_out, e.sx);
      chk("rt_out", {27'd0, rt_out}, {27'd0, e.rt});
      chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
      chk("instr_count", instr_count, stats_on ? e.ic : 32'd0);
      chk("bubble_count", bubble_count, stats_on ? e.bc : 32'd0);
    end
  end

  // Drive one decode-stage cycle; exp_stall is the hand-derived hazard outcome.
  task automatic step(input logic fl, input logic v, input logic [1:0] wb, input logic [2:0] m,
                      input logic [3:0] ex, input logic [31:0] npc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] sx, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic exp_stall);
    @(negedge clk);
    flush = fl; valid_in = v; ctlwb_in = wb; ctlm_in = m; ctlex_in = ex;
    npc_in = npc; A_in = a; B_in = b; signext_in = sx; rs_in = rs; rt_in = rt; rd_in = rd;
    #1;
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    if (fl || exp_stall) begin
      cur.v = 1'b0; cur.wb = '0; cur.m = '0; cur.ex = '0;
      cur.bc = cur.bc + 32'd1;
    end else begin
      cur.v = v; cur.wb = wb; cur.m = m; cur.ex = ex;
      cur.npc = npc; cur.a = a; cur.b = b; cur.sx = sx; cur.rt = rt; cur.rd = rd;
      if (v) cur.ic = cur.ic + 32'd1;
    end
    q.push_back(cur);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_ctl"}, {23'd0, ctlwb_out, ctlm_out, ctlex_out}, 32'd0);
    chk({tag, "_A"}, A_out, 32'd0);
    chk({tag, "_B"}, B_out, 32'd0);
    chk({tag, "_npc"}, npc_out, 32'd0);
    chk({tag, "_sx"}, signext_out, 32'd0);
    chk({tag, "_rtrd"}, {22'd0, rt_out, rd_out}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_cnt"}, instr_count | bubble_count, 32'd0);
  endtask

  initial begin
`ifdef ID_EX_STATS_EN
    stats_on = 1'b1;
`else
    stats_on = 1'b0;
`endif
    cur = '0;
    #13;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    //   fl v  wb     m       ex       npc    A      B      sx     rs  rt  rd  stall
    step(0, 1, 2'b10, 3'b000, 4'b1000, 32'h4, 32'd5, 32'd7, 32'd0, 1,  2,  3,  0);
    // load-use: lw rt=8 then consumer rs=8 stalls once, then proceeds
    step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h8, 32'd10, 32'd20, 32'd100, 1, 8, 0, 0);
    step(0, 1, 2'b10, 3'b000, 4'b1100, 32'hc, 32'd11, 32'd22, 32'd0, 8, 9, 10, 1);
    step(0, 1, 2'b10, 3'b000, 4'b1100, 32'hc, 32'd11, 32'd22, 32'd0, 8, 9, 10, 0);
    // lw to $zero never hazards
    step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h10, 32'd1, 32'd0, 32'd4, 2, 0, 0, 0);
    step(0, 1, 2'b10, 3'b000, 4'b1100, 32'h14, 32'd2, 32'd3, 32'd0, 0, 0, 5, 0);
    // lw rt=8 followed by unrelated rs=9, rt=10
    step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h18, 32'd6, 32'd0, 32'd8, 3, 8, 0, 0);
    step(0, 1, 2'b10, 3'b000, 4'b1100, 32'h1c, 32'd7, 32'd8, 32'd0, 9, 10, 11, 0);
    // flush: bubble, data fields keep previous values
    step(1, 1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'd99, 32'd98, 32'd97, 1, 2, 3, 0);
    // flush coinciding with a load-use stall: exactly one bubble
    step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h24, 32'd30, 32'd0, 32'd12, 4, 8, 0, 0);
    step(1, 1, 2'b10, 3'b000, 4'b1100, 32'h28, 32'd31, 32'd32, 32'd0, 8, 6, 7, 1);
    step(0, 1, 2'b10, 3'b000, 4'b1100, 32'h2c, 32'd33, 32'd34, 32'd0, 5, 8, 7, 0);
    // valid_in=0 with matching rs must not stall
    step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h30, 32'd40, 32'd0, 32'd16, 4, 8, 0, 0);
    step(0, 0, 2'b00, 3'b000, 4'b0000, 32'h34, 32'd41, 32'd42, 32'd0, 8, 8, 0, 0);
    // reset mid-operation with a pending load-use hazard
    step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h38, 32'd50, 32'd0, 32'd20, 4, 8, 0, 0);
    @(negedge clk);
    rs_in = 5'd8; valid_in = 1'b1; ctlm_in = 3'b000;
    #1;
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    #1; rst = 1'b1; #1;
    check_all_zero("midreset");
    @(negedge clk); rst = 1'b0; cur = '0;
    step(0, 1, 2'b10, 3'b000, 4'b1100, 32'h3c, 32'd60, 32'd61, 32'd0, 8, 9, 1, 0);
    // 10 instructions back-to-back; #4 (lw rt=12) feeds #5 (rt=12) once
    for (int i = 0; i < 10; i++) begin
      if (i == 4)
        step(0, 1, 2'b11, 3'b010, 4'b0001, 32'h100 + i, 32'd100 + i, 32'd0, 32'd4, 1, 12, 0, 0);
      else
        step(0, 1, 2'b10, 3'b000, 4'b1100, 32'h100 + i, 32'd100 + i, 32'd200 + i, 32'd0,
             5'd2, (i == 5) ? 5'd12 : 5'd3, 5'd4, (i == 5) ? 1'b1 : 1'b0);
      if (i == 5)
        step(0, 1, 2'b10, 3'b000, 4'b1100, 32'h105, 32'd105, 32'd205, 32'd0, 2, 12, 4, 0);
    end
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    chk("final_instr_count", instr_count, stats_on ? 32'd11 : 32'd0);
    chk("final_bubble_count", bubble_count, stats_on ? 32'd1 : 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
